prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 272 +++++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: UART (8N1) program-memory loader.
// Receives a framed program image over RXD and writes 16-bit words into
// program memory, holding the CPU in reset while a load is in progress.
// Frame: HDR_BYTE, word count N (0 = 256), N x {hi, lo}, [checksum].
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing 8-bit sum
// byte (mod-256 sum of every hi/lo byte) that must match before release.
// Ports:
//   CLK         single clock
//   nRESET      asynchronous active-low reset
//   RXD         UART serial input (asynchronous, idle high)
//   PADDR       program-memory word address
//   PDATA       program-memory write word
//   PWE         one-cycle write strobe
//   CPU_nRESET  active-low CPU reset
//   BUSY        load in progress
//   ERR         sticky load error (framing or checksum)
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        RXD,
  output logic [7:0]  PADDR,
  output logic [15:0] PDATA,
  output logic        PWE,
  output logic        CPU_nRESET,
  output logic        BUSY,
  output logic        ERR
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  typedef enum logic [2:0] {
    L_IDLE, L_CNT, L_HI, L_LO, L_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
    , L_SUM
`endif
  } load_state_e;

  // RXD synchroniser plus one extra stage for falling-edge detection
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

  uart_state_e ustate_q, ustate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frm_err_q, frm_err_d;

  load_state_e lstate_q, lstate_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [15:0] pdata_q, pdata_d;
  logic        pwe_q, pwe_d;
  logic        cpu_nreset_q, cpu_nreset_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [1:0]  rel_q, rel_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  // UART receiver: start re-check at half bit, then full-bit spaced samples
  always_comb begin
    ustate_d   = ustate_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    frm_err_d  = 1'b0;
    case (ustate_q)
      U_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          ustate_d = U_START;
          cnt_d    = HALF_LAST;
        end
      end
      U_START: begin
        if (cnt_q == '0) begin
          if (!rxd_s2_q) begin
            ustate_d  = U_DATA;
            cnt_d     = BIT_LAST;
            bit_idx_d = 3'd0;
          end else begin
            ustate_d = U_IDLE;    // glitch: silently abandon
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      U_DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          cnt_d     = BIT_LAST;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) ustate_d = U_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      U_STOP: begin
        if (cnt_q == '0) begin
          if (rxd_s2_q) rx_valid_d = 1'b1;
          else          frm_err_d  = 1'b1;
          ustate_d = U_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ustate_d = U_IDLE;
    endcase
  end

  // Load sequencer
  always_comb begin
    lstate_d     = lstate_q;
    rem_d        = rem_q;
    paddr_d      = paddr_q;
    pdata_d      = pdata_q;
    pwe_d        = 1'b0;
    cpu_nreset_d = cpu_nreset_q;
    busy_d       = busy_q;
    err_d        = err_q;
    rel_d        = {rel_q[0], 1'b1};
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    // Address advances in the cycle after the strobe so it is stable during PWE
    if (pwe_q) paddr_d = paddr_q + 8'd1;
    // One-shot CPU release on the second clock after reset deassertion
    if (rel_q == 2'b01) cpu_nreset_d = 1'b1;

    if (frm_err_q) begin
      // Any framing error is fatal to the load; CPU held while ERR is set
      err_d        = 1'b1;
      busy_d       = 1'b0;
      cpu_nreset_d = 1'b0;
      lstate_d     = L_IDLE;
    end else begin
      case (lstate_q)
        L_IDLE: begin
          if (rx_valid_q && (shift_q == HDR_BYTE)) begin
            lstate_d     = L_CNT;
            cpu_nreset_d = 1'b0;
            busy_d       = 1'b1;
            err_d        = 1'b0;
            paddr_d      = 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d        = 8'd0;
`endif
          end
        end
        L_CNT: begin
          if (rx_valid_q) begin
            rem_d    = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
            lstate_d = L_HI;
          end
        end
        L_HI: begin
          if (rx_valid_q) begin
            pdata_d[15:8] = shift_q;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d         = sum_q + shift_q;
`endif
            lstate_d      = L_LO;
          end
        end
        L_LO: begin
          if (rx_valid_q) begin
            pdata_d[7:0] = shift_q;
            pwe_d        = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d        = sum_q + shift_q;
`endif
            rem_d        = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              lstate_d = L_SUM;
`else
              lstate_d = L_DONE;
`endif
            end else begin
              lstate_d = L_HI;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        L_SUM: begin
          if (rx_valid_q) begin
            if (shift_q == sum_q) begin
              lstate_d = L_DONE;
            end else begin
              err_d    = 1'b1;
              busy_d   = 1'b0;
              lstate_d = L_IDLE;
            end
          end
        end
`endif
        L_DONE: begin
          busy_d       = 1'b0;
          cpu_nreset_d = 1'b1;
          lstate_d     = L_IDLE;
        end
        default: lstate_d = L_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      rxd_prev_q   <= 1'b1;
      ustate_q     <= U_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      rx_valid_q   <= 1'b0;
      frm_err_q    <= 1'b0;
      lstate_q     <= L_IDLE;
      rem_q        <= 9'd0;
      paddr_q      <= 8'd0;
      pdata_q      <= 16'd0;
      pwe_q        <= 1'b0;
      cpu_nreset_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      rel_q        <= 2'b00;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= 8'd0;
`endif
    end else begin
      rxd_s1_q     <= RXD;
      rxd_s2_q     <= rxd_s1_q;
      rxd_prev_q   <= rxd_s2_q;
      ustate_q     <= ustate_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_valid_q   <= rx_valid_d;
      frm_err_q    <= frm_err_d;
      lstate_q     <= lstate_d;
      rem_q        <= rem_d;
      paddr_q      <= paddr_d;
      pdata_q      <= pdata_d;
      pwe_q        <= pwe_d;
      cpu_nreset_q <= cpu_nreset_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      rel_q        <= rel_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign PADDR      = paddr_q;
  assign PDATA      = pdata_q;
  assign PWE        = pwe_q;
  assign CPU_nRESET = cpu_nreset_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// Testbench for prog_loader: directed and randomized program loads over a
// bit-banged UART, checked against expected write lists and end states.
module tb_prog_loader;

  localparam int unsigned CPB = 8;
  localparam logic [7:0]  HDR = 8'hA5;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        RXD;
  logic [7:0]  PADDR;
  logic [15:0] PDATA;
  logic        PWE;
  logic        CPU_nRESET;
  logic        BUSY;
  logic        ERR;

  int total = 0;
  int bad   = 0;

  logic [23:0] wq[$];
  logic [15:0] words[256];
  int          pwe_run  = 0;
  int          pwe_long = 0;

  prog_loader #(.CLKS_PER_BIT(CPB), .HDR_BYTE(HDR)) dut (
    .CLK(CLK), .nRESET(nRESET), .RXD(RXD),
    .PADDR(PADDR), .PDATA(PDATA), .PWE(PWE),
    .CPU_nRESET(CPU_nRESET), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Write monitor: record every strobe and any strobe wider than one cycle
  always @(negedge CLK) begin
    if (PWE === 1'b1) begin
      wq.push_back({PADDR, PDATA});
      pwe_run = pwe_run + 1;
      if (pwe_run > 1) pwe_long = pwe_long + 1;
    end else begin
      pwe_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    RXD = 1'b0;
    repeat (CPB) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(posedge CLK);
    end
    RXD = stop_ok;
    repeat (CPB) @(posedge CLK);
    RXD = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(posedge CLK);
    repeat ($urandom_range(0, 3)) @(posedge CLK);
  endtask

  task automatic check_outputs_idle_state(input string tag, input bit exp_err, input bit exp_cpu);
    check({tag, ".busy"}, 32'(BUSY), 32'(0));
    check({tag, ".err"},  32'(ERR),  32'(exp_err));
    check({tag, ".cpu"},  32'(CPU_nRESET), 32'(exp_cpu));
  endtask

  // Full load of words[0..n-1]; good selects a correct or corrupted checksum
  task automatic do_load(input string tag, input int n, input bit good);
    logic [7:0] s;
    bit ok;
    int lim;
    s = 8'd0;
    wq.delete();
    send_byte(HDR);
    send_byte(8'(n));
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check({tag, ".busy_mid"}, 32'(BUSY), 32'(1));
    check({tag, ".cpu_mid"},  32'(CPU_nRESET), 32'(0));
    check({tag, ".err_mid"},  32'(ERR), 32'(0));
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
      s = 8'(s + words[i][15:8] + words[i][7:0]);
    end
    if (CHK_EN) send_byte(good ? s : 8'(s + 8'd1));
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    ok = !CHK_EN || good;
    check({tag, ".nwrites"}, 32'(wq.size()), 32'(n));
    lim = (wq.size() < n) ? wq.size() : n;
    for (int i = 0; i < lim; i++)
      check({tag, ".write"}, 32'(wq[i]), 32'({8'(i), words[i]}));
    check({tag, ".pdata"}, 32'(PDATA), 32'(words[n-1]));
    check({tag, ".paddr"}, 32'(PADDR), 32'(8'(n)));
    check_outputs_idle_state(tag, !ok, ok);
  endtask

  initial begin
    int n;
    bit good;
    nRESET = 1'b0;
    RXD    = 1'b1;

    // Reset values and post-reset CPU release timing
    repeat (3) @(negedge CLK);
    check("rst.paddr", 32'(PADDR), 32'(0));
    check("rst.pdata", 32'(PDATA), 32'(0));
    check("rst.pwe",   32'(PWE),   32'(0));
    check_outputs_idle_state("rst", 1'b0, 1'b0);
    nRESET = 1'b1;
    @(negedge CLK);
    check("rel.cpu_edge1", 32'(CPU_nRESET), 32'(0));
    @(negedge CLK);
    check("rel.cpu_edge2", 32'(CPU_nRESET), 32'(1));
    repeat (5) @(posedge CLK);

    // Two-word load
    words[0] = 16'h1234; words[1] = 16'h5678;
    do_load("two_word", 2, 1'b1);

    // Bad checksum, then recovery
    words[0] = 16'hABCD;
    do_load("bad_sum", 1, 1'b0);
    do_load("recover", 1, 1'b1);

    // Short RXD glitch in idle must not disturb anything
    wq.delete();
    @(posedge CLK);
    RXD = 1'b0;
    repeat (CPB / 2) @(posedge CLK);
    RXD = 1'b1;
    repeat (12 * CPB) @(posedge CLK);
    @(negedge CLK);
    check("glitch.nwrites", 32'(wq.size()), 32'(0));
    check_outputs_idle_state("glitch", 1'b0, 1'b1);

    // Framing error on the first data byte
    wq.delete();
    send_byte(HDR);
    send_byte(8'h01);
    send_byte(8'h12, 1'b0);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("frame.nwrites", 32'(wq.size()), 32'(0));
    check_outputs_idle_state("frame", 1'b1, 1'b0);

    // Reset between the hi and lo bytes abandons the load
    wq.delete();
    send_byte(HDR);
    send_byte(8'h01);
    send_byte(8'hAB);
    @(negedge CLK);
    nRESET = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst.paddr", 32'(PADDR), 32'(0));
    check("midrst.pdata", 32'(PDATA), 32'(0));
    check("midrst.pwe",   32'(PWE),   32'(0));
    check_outputs_idle_state("midrst", 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    check("midrst.cpu_edge1", 32'(CPU_nRESET), 32'(0));
    @(negedge CLK);
    check("midrst.cpu_edge2", 32'(CPU_nRESET), 32'(1));
    send_byte(8'hCD);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("midrst.nwrites", 32'(wq.size()), 32'(0));
    check_outputs_idle_state("midrst_after", 1'b0, 1'b1);

    // Single word, header value appearing as data
    words[0] = {HDR, HDR};
    do_load("hdr_data", 1, 1'b1);
    words[0] = 16'hBEEF;
    do_load("beef", 1, 1'b1);

    // Full 256-word load with address wrap
    for (int i = 0; i < 256; i++) words[i] = 16'(i);
    do_load("full256", 256, 1'b1);
    check("pwe.width", 32'(pwe_long), 32'(0));

    // Randomized loads
    for (int k = 0; k < 5; k++) begin
      n    = int'($urandom_range(1, 5));
      good = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      do_load("random", n, good);
    end
    check("pwe.width_end", 32'(pwe_long), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
